// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Responder end of the CPU data-memory bus. Holds a word-organised data RAM
// and serves single-word loads and stores. Each access is latched on accept,
// held for WAIT_CYCLES wait states, then completed with a one-cycle mem_ready
// strobe. Protocol errors (MemRead and MemWrite together) and out-of-range
// accesses are reported on mem_err.
//
// Configuration macro:
//   DMEM_ALIGN_CHECK_EN  when defined, DAB[2:0] != 0 is treated as an error
//                        (no store, zero load data, mem_err with mem_ready).
//                        When undefined, DAB[2:0] is ignored.
//
// Parameters:
//   WORD         data/address width in bits
//   DEPTH        number of WORD-wide RAM entries (index = DAB[3 +: clog2(DEPTH)])
//   WAIT_CYCLES  wait states between accept and response (0 allowed)
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   DAB        byte address from the initiator
//   DDB        bidirectional data bus; driven here only during a load response
//   MemRead    load request
//   MemWrite   store request, write data presented on DDB
//   mem_ready  one-cycle completion strobe (registered)
//   mem_err    one-cycle error strobe (registered)
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int WORD        = 64,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] DAB,
    inout  wire  [WORD-1:0] DDB,
    input  logic            MemRead,
    input  logic            MemWrite,
    output logic            mem_ready,
    output logic            mem_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [WORD-4:0]   DEPTH_LIM = (WORD-3)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt_q;

    // Request captured on accept
    logic [IDX_W-1:0]   idx_q;
    logic [WORD-1:0]    wdata_q;
    logic               is_store_q;
    logic               bad_q;

    logic               ready_d;
    logic               err_d;
    logic               drive_en;
    logic [WORD-1:0]    rd_word;

    logic [WORD-1:0]    mem [DEPTH];

    wire req_one  = MemRead ^ MemWrite;
    wire req_both = MemRead & MemWrite;
    wire accept   = (state == S_IDLE) && req_one;

    // Error condition of the address currently on the bus
    logic dab_range_bad;
    logic dab_align_bad;
    logic dab_bad;
    assign dab_range_bad = (DAB[WORD-1:3] >= DEPTH_LIM);

`ifdef DMEM_ALIGN_CHECK_EN
    assign dab_align_bad = |DAB[2:0];
`else
    logic unused_dab_low;
    assign unused_dab_low = ^DAB[2:0];
    assign dab_align_bad  = 1'b0;
`endif

    assign dab_bad = dab_range_bad | dab_align_bad;

    // ------------------------------------------------------------------
    // State register, wait counter and registered strobes
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt_q     <= '0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state     <= next_state;
            mem_ready <= ready_d;
            mem_err   <= err_d;
            if (state == S_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req_one) begin
                    next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    next_state = S_RESP;
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered strobes, and the bus
    // drive enable which depends on registered state only.
    // ------------------------------------------------------------------
    always_comb begin
        ready_d  = 1'b0;
        err_d    = 1'b0;
        drive_en = 1'b0;
        if (next_state == S_RESP) begin
            ready_d = 1'b1;
            // With zero wait states the address is still on the bus when
            // RESP is entered, so the error comes from DAB directly.
            err_d   = (state == S_IDLE) ? dab_bad : bad_q;
        end
        if ((state == S_IDLE) && req_both) begin
            err_d = 1'b1;
        end
        if ((state == S_RESP) && !is_store_q) begin
            drive_en = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Request capture (data path only, meaningful only after an accept)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q      <= DAB[3 +: IDX_W];
            is_store_q <= MemWrite;
            wdata_q    <= DDB;
            bad_q      <= dab_bad;
        end
    end

    // ------------------------------------------------------------------
    // RAM: store commits at the edge ending RESP; a reset on that edge or
    // earlier discards it.
    // ------------------------------------------------------------------
    // NOTE: the RAM array has no reset; clearing it would turn the storage
    // into thousands of resettable flops instead of an inferable memory.
    always_ff @(posedge clk) begin
        if (!rst && (state == S_RESP) && is_store_q && !bad_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign rd_word = bad_q ? '0 : mem[idx_q];
    assign DDB     = drive_en ? rd_word : 'z;

endmodule
